// File: rtl/spi_fsm_pkg.sv
// Shared types and constants for the SPI peripheral control FSM.
// Holds the state encoding, default sizing and the state-to-enable decode.
package spi_fsm_pkg;

    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_CNT_W = 4;
    localparam logic RW_READ   = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_ADDR   = 3'd1,
        GOT_ADDR   = 3'd2,
        READ_LOAD  = 3'd3,
        READ_SHIFT = 3'd4,
        WRITE_GET  = 3'd5,
        WRITE_DM   = 3'd6,
        DONE       = 3'd7
    } stateT;

    typedef struct packed {
        logic srWe;
        logic addrWe;
        logic dmWe;
        logic misoBufe;
        logic busy;
    } fsmOutT;

    // Moore decode: the enables depend on the current state alone.
    function automatic fsmOutT decodeState(input stateT s);
        fsmOutT o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            GOT_ADDR:   o.addrWe   = 1'b1;
            READ_LOAD:  o.srWe     = 1'b1;
            READ_SHIFT: o.misoBufe = 1'b1;
            WRITE_DM:   o.dmWe     = 1'b1;
            default:    ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// Bit counter for the SPI control FSM.
// A synchronous clear takes priority over an increment.
module bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is updated with <= so every flop samples
    // pre-edge values; the async reset gives a known value without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// Control FSM of the SPI memory peripheral: generates shift-register load,
// address latch, data-memory write and MISO buffer enables from SCLK edges.
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic sr_we,
    output logic addr_we,
    output logic dm_we,
    output logic miso_bufe,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    stateT            state;
    stateT            nextState;
    logic             cntClr;
    logic             cntInc;
    logic [CNT_W-1:0] count;
    fsmOutT           outs;

    bit_counter #(.CNT_W(CNT_W)) bitCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cntClr),
        .inc   (cntInc),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        nextState = state;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        if (state != IDLE && cs_n) begin
            // Deselect overrides terminal count and every other transition.
            nextState = IDLE;
            cntClr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cntClr = 1'b1;
                    if (!cs_n) begin
                        nextState = GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (sclk_pos) begin
                        if (count == LAST_BIT) begin
                            nextState = GOT_ADDR;
                            cntClr    = 1'b1;
                        end else begin
                            cntInc = 1'b1;
                        end
                    end
                end
                GOT_ADDR: begin
                    nextState = (rw_bit == RW_READ) ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    nextState = READ_SHIFT;
                end
                READ_SHIFT: begin
                    // Data leaves on falling edges while MISO is driven.
                    if (sclk_neg) begin
                        if (count == LAST_BIT) begin
                            nextState = DONE;
                            cntClr    = 1'b1;
                        end else begin
                            cntInc = 1'b1;
                        end
                    end
                end
                WRITE_GET: begin
                    if (sclk_pos) begin
                        if (count == LAST_BIT) begin
                            nextState = WRITE_DM;
                            cntClr    = 1'b1;
                        end else begin
                            cntInc = 1'b1;
                        end
                    end
                end
                WRITE_DM: begin
                    nextState = DONE;
                end
                DONE: begin
                    nextState = DONE;
                end
                default: begin
                    nextState = IDLE;
                    cntClr    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        outs = decodeState(state);
    end

    assign sr_we     = outs.srWe;
    assign addr_we   = outs.addrWe;
    assign dm_we     = outs.dmWe;
    assign miso_bufe = outs.misoBufe;
    assign busy      = outs.busy;

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: a per-cycle input log is replayed against
// a timeline model of the SPI transaction to predict every enable.
`timescale 1ns/1ps
module tb_spi_fsm;
    import spi_fsm_pkg::*;

    localparam int WIDTH  = DEF_WIDTH;
    localparam int MAXCYC = 16384;

    logic clk = 1'b0;
    logic rst_n, cs_n, sclk_pos, sclk_neg, rw_bit;
    logic sr_we, addr_we, dm_we, miso_bufe, busy;

    spi_fsm #(.WIDTH(WIDTH), .CNT_W(DEF_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .sr_we     (sr_we),
        .addr_we   (addr_we),
        .dm_we     (dm_we),
        .miso_bufe (miso_bufe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic srWe;
        logic addrWe;
        logic dmWe;
        logic misoBufe;
        logic busy;
    } expT;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit active      = 1'b0;
    int sessStart   = 0;
    bit csA  [MAXCYC];
    bit posA [MAXCYC];
    bit negA [MAXCYC];
    bit rwA  [MAXCYC];

    // Expected enables in cycle t of a transaction whose first selected
    // cycle is s. Inputs of cycle c take effect from cycle c+1.
    function automatic expT expectAt(input int s, input int t);
        expT e  = '0;
        int  n  = 0;
        int  a8 = -1;
        int  e8 = -1;
        bit  rd;
        e.busy = 1'b1;
        for (int c = s; c < t; c++) begin
            if (posA[c]) begin
                n++;
                if (n == WIDTH) begin a8 = c; break; end
            end
        end
        if (a8 < 0) return e;
        if (t == a8 + 1) begin e.addrWe = 1'b1; return e; end
        rd = rwA[a8 + 1];
        if (rd && t == a8 + 2) begin e.srWe = 1'b1; return e; end
        n = 0;
        if (rd) begin
            for (int c = a8 + 3; c < t; c++) begin
                if (negA[c]) begin
                    n++;
                    if (n == WIDTH) begin e8 = c; break; end
                end
            end
            if (e8 < 0) e.misoBufe = 1'b1;
        end else begin
            for (int c = a8 + 2; c < t; c++) begin
                if (posA[c]) begin
                    n++;
                    if (n == WIDTH) begin e8 = c; break; end
                end
            end
            if (e8 >= 0 && t == e8 + 1) e.dmWe = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        expT e = '0;
        if (active) e = expectAt(sessStart, cyc);
        check("sr_we",     sr_we,     e.srWe);
        check("addr_we",   addr_we,   e.addrWe);
        check("dm_we",     dm_we,     e.dmWe);
        check("miso_bufe", miso_bufe, e.misoBufe);
        check("busy",      busy,      e.busy);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // One clock: advance the model across the edge, check, then drive.
    task automatic step(input bit c, input bit p, input bit n, input bit r);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXCYC) begin
            $display("FAIL cycle_budget: observed %0d cycles, required below %0d", cyc, MAXCYC);
            $fatal(1);
        end
        if (!rst_n) begin
            active = 1'b0;
        end else if (!active && !csA[cyc-1]) begin
            active    = 1'b1;
            sessStart = cyc;
        end else if (active && csA[cyc-1]) begin
            active = 1'b0;
        end
        checkOutputs();
        cs_n = c; sclk_pos = p; sclk_neg = n; rw_bit = r;
        csA[cyc] = c; posA[cyc] = p; negA[cyc] = n; rwA[cyc] = r;
    endtask

    task automatic assertReset();
        #2 rst_n = 1'b0;
        #1;
        active = 1'b0;
        check("rst_sr_we",     sr_we,     1'b0);
        check("rst_addr_we",   addr_we,   1'b0);
        check("rst_dm_we",     dm_we,     1'b0);
        check("rst_miso_bufe", miso_bufe, 1'b0);
        check("rst_busy",      busy,      1'b0);
    endtask

    task automatic releaseReset();
        #2 rst_n = 1'b1;
    endtask

    // Random gap, then one pulse of the requested polarity plus random noise.
    task automatic gapThenPulse(input bit usePos, input bit r);
        int g = int'($urandom_range(0, 2));
        for (int i = 0; i < g; i++) begin
            if (usePos) step(1'b0, 1'b0, rb(), r);
            else        step(1'b0, rb(), 1'b0, r);
        end
        if (usePos) step(1'b0, 1'b1, rb(), r);
        else        step(1'b0, rb(), 1'b1, r);
    endtask

    // Transaction after cs_n is already low: address, data, DONE hold, deselect.
    task automatic body(input bit rd, input int abortAt, input int extra);
        for (int i = 0; i < WIDTH; i++) gapThenPulse(1'b1, rd);
        step(1'b0, rb(), rb(), rd);
        if (rd) step(1'b0, rb(), rb(), rd);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == abortAt) break;
            gapThenPulse(!rd, rd);
        end
        if (abortAt < 0) begin
            step(1'b0, 1'b0, 1'b0, rd);
            step(1'b0, 1'b0, 1'b0, rd);
            for (int i = 0; i < extra; i++) step(1'b0, rb(), rb(), rb());
        end
        step(1'b1, rb(), rb(), rd);
        step(1'b1, 1'b0, 1'b0, rd);
        step(1'b1, 1'b0, 1'b0, rd);
    endtask

    task automatic transaction(input bit rd, input int abortAt, input int extra);
        step(1'b0, 1'b0, 1'b0, rd);
        body(rd, abortAt, extra);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
        csA[0] = 1'b1; posA[0] = 1'b0; negA[0] = 1'b0; rwA[0] = 1'b0;
        #1;
        checkOutputs();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        releaseReset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Directed read and write, each with pulses while holding in DONE.
        transaction(1'b1, -1, 4);
        transaction(1'b0, -1, 4);

        // Abort after 5 data pulses, then a clean restart from count 0.
        transaction(1'b0, 5, 0);
        transaction(1'b0, -1, 0);

        // Deselect in the same cycle as the 8th address pulse.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIDTH - 1; i++) gapThenPulse(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-address with cs_n held low; restart must count from zero.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) gapThenPulse(1'b1, 1'b1);
        assertReset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        releaseReset();
        body(1'b1, -1, 2);

        // Randomised transactions with occasional aborts and idle gaps.
        repeat (40) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
            transaction(rb(), ab, int'($urandom_range(0, 4)));
            repeat (int'($urandom_range(0, 2))) step(1'b1, rb(), rb(), rb());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Control FSM for the SPI memory peripheral. It sequences the 8-bit shift register's parallel-load, the address latch, the data-memory write and the MISO tri-state buffer from conditioned SCLK edge pulses and chip-select. It sits between the input conditioners (synchronised `cs_n`, one-cycle SCLK edge pulses) and the shift register, address latch and data memory. It only generates enables; the datapath wiring is outside it.

## Interface
- `WIDTH`, 8: bits per SPI byte; address byte and data byte are both `WIDTH` bits.
- `CNT_W`, 4: bit-counter width; must satisfy 2^`CNT_W` > `WIDTH`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cs_n` input 1: conditioned chip select, active low, synchronous to `clk`.
- `sclk_pos` input 1: one-`clk` pulse per SCLK rising edge. This is the same signal that drives the shift register's `peripheralClkEdge`.
- `sclk_neg` input 1: one-`clk` pulse per SCLK falling edge.
- `rw_bit` input 1: `parallelDataOut[0]` of the shift register; 1 = read, 0 = write.
- `sr_we` output 1: shift-register `parallelLoad`.
- `addr_we` output 1: address latch write enable.
- `dm_we` output 1: data memory write enable.
- `miso_bufe` output 1: MISO tri-state buffer enable.
- `busy` output 1: high in every state except IDLE.

## Operation
- Moore machine; every output is decoded from the state register only.
- States:
  - IDLE: all outputs 0.
  - GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_DM, DONE: outputs as listed per transition below.
- IDLE → GET_ADDR when `cs_n`=0. Counter is cleared.
- GET_ADDR: counter increments on each `sclk_pos`. When `sclk_pos`=1 and count = `WIDTH`-1, the next state is GOT_ADDR and the counter clears.
- GOT_ADDR (1 cycle): `addr_we`=1. Next state is READ_LOAD if `rw_bit`=1, else WRITE_GET.
- READ_LOAD (1 cycle): `sr_we`=1. Next state is READ_SHIFT.
- READ_SHIFT: `miso_bufe`=1. Counter increments on each `sclk_neg`. When the `WIDTH`-th `sclk_neg` arrives, next state is DONE.
- WRITE_GET: counter increments on each `sclk_pos`. When the `WIDTH`-th `sclk_pos` arrives, next state is WRITE_DM.
- WRITE_DM (1 cycle): `dm_we`=1. Next state is DONE.
- DONE: all enables 0. Stays in DONE until `cs_n`=1; further SCLK edges are ignored.
- `cs_n`=1 in any non-IDLE state forces the next state to IDLE and clears the counter. This has priority over terminal count and over every other transition.
- Edge pulses are ignored in IDLE, GOT_ADDR, READ_LOAD, WRITE_DM and DONE.
- The counter never wraps. It clears on every terminal count and on every entry to IDLE.
- `sclk_pos` and `sclk_neg` high in the same cycle: only the pulse relevant to the current state is counted.

## Timing
- Reset (`rst_n`=0, asynchronous): state = IDLE, counter = 0. `sr_we`, `addr_we`, `dm_we`, `miso_bufe` and `busy` are all 0 immediately, independent of `clk`.
- Reset release: takes effect on the next `clk` rising edge.
- Reset asserted mid-transaction: the FSM aborts to IDLE. It does not restart until `cs_n` is observed low again; a `cs_n` already low counts.
- `cs_n` fall → `busy` high 1 cycle later.
- Counting starts with the first `sclk_pos` in the cycle after entering GET_ADDR.
- 8th address `sclk_pos` in cycle N:
  - shift register shifts at the end of N.
  - GOT_ADDR in cycle N+1, `addr_we` high.
  - Read path: READ_LOAD in N+2 (`sr_we` high); shift register holds the memory byte at the end of N+2.
  - Read path: `miso_bufe` high from N+3.
- Write path: 8th data `sclk_pos` in cycle M → `dm_we` high in M+1 → DONE in M+2.
- `cs_n` rise in cycle K → IDLE in K+1, with all enables low in K+1.

## Structure
- Package `spi_fsm_pkg`:
  - state enum (8 states, 3-bit encoding, IDLE = 0).
  - default `WIDTH`/`CNT_W` constants.
  - `RW_READ` = 1'b1.
- Sub-module `bit_counter`:
  - ports: `clk`, `rst_n`, `clr`, `inc`, `count`.
  - synchronous clear has priority over increment.
- `spi_fsm` contains the state register, next-state logic, output decode and one `bit_counter` instance.

## Test plan
- Reset: drive `rst_n`=0 with `cs_n`=0 mid-GET_ADDR → all outputs 0 immediately. After release with `cs_n` held low → GET_ADDR next cycle, `busy`=1, count 0.
- Read transaction: `cs_n`=0, 8 `sclk_pos` pulses with `rw_bit`=1 after the 8th → `addr_we` single pulse at N+1, `sr_we` single pulse at N+2. `miso_bufe` high from N+3 until 8 `sclk_neg` pulses, then 0 in DONE.
- Write transaction: 8 address pulses with `rw_bit`=0, then 8 data `sclk_pos` pulses → exactly one `dm_we` pulse the cycle after the 16th pulse. `sr_we` and `miso_bufe` never asserted.
- Abort: raise `cs_n` after 5 data pulses in WRITE_GET → IDLE next cycle, no `dm_we`. A new `cs_n` fall restarts with count 0.
- DONE hold: 4 extra `sclk_pos`/`sclk_neg` pulses after WRITE_DM with `cs_n` low → state remains DONE, no enables asserted.
- Priority: `cs_n`=1 in the same cycle as the 8th address `sclk_pos` → IDLE, `addr_we` never asserted.
